// File: rtl/mutex_pkg.sv
// Shared types for the mutual-exclusion invariant monitor: node states, monitor FSM states
// and the legal-successor rule.
package mutex_pkg;

   typedef enum logic [1:0] {
      NodeIdle = 2'd0,
      NodeTry  = 2'd1,
      NodeCrit = 2'd2,
      NodeExit = 2'd3
   } node_state_e;

   typedef enum logic [1:0] {
      MonArm  = 2'd0,
      MonRun  = 2'd1,
      MonFail = 2'd2
   } mon_state_e;

   // A node may hold its state or advance one step around IDLE->TRY->CRIT->EXIT->IDLE.
   function automatic logic legal_step(node_state_e prev, node_state_e next);
      node_state_e succ;
      succ = node_state_e'(prev + 2'd1);
      return (next == prev) || (next == succ);
   endfunction

endpackage

// File: rtl/mutex_node_checker.sv
// Per-node checker: remembers the previous state, flags illegal steps and runs the
// starvation watchdog for time spent in TRY.
module mutex_node_checker
   import mutex_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       check_trans,
   input  logic [1:0] node_state,
   output logic       trans_err,
   output logic       starve_err,
   output logic       in_crit,
   output logic       holds_lock
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LastOk   = CNT_W'(STARVE_LIMIT - 1);

   node_state_e      cur_st;
   node_state_e      prev_q;
   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;

   assign cur_st = node_state_e'(node_state);

   always_comb begin
      starve_cnt_d = '0;
      if (cur_st == NodeTry) begin
         starve_cnt_d = (starve_cnt_q == LimitCnt) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end
   end

   // The counter holds the number of earlier consecutive TRY samples, so the sample that
   // completes STARVE_LIMIT cycles in TRY is the one flagged.
   assign starve_err = (cur_st == NodeTry) && (starve_cnt_q >= LastOk);
   assign trans_err  = check_trans && !legal_step(prev_q, cur_st);
   assign in_crit    = (cur_st == NodeCrit);
   assign holds_lock = (cur_st == NodeCrit) || (cur_st == NodeExit);

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q       <= NodeIdle;
         starve_cnt_q <= '0;
      end else begin
         prev_q       <= cur_st;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mutex_invariant_monitor.sv
// Invariant monitor for the mutual-exclusion system: mutex, lock-consistency, transition and
// starvation checks with sticky flags and first-failure capture.
module mutex_invariant_monitor
   import mutex_pkg::*;
#(
   parameter  int unsigned NODES        = 3,
   parameter  int unsigned STARVE_LIMIT = 16,
   parameter  int unsigned CYC_W        = 16,
   localparam int unsigned NODE_W       = (NODES > 1) ? $clog2(NODES) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [2*NODES-1:0]   io_n_state,
   input  logic                 io_x,
   input  logic [NODES-1:0]     io_en_a,
   output logic                 io_armed,
   output logic                 io_err_mutex,
   output logic                 io_err_lock,
   output logic                 io_err_trans,
   output logic                 io_err_starve,
   output logic                 io_fail,
   output logic [NODE_W-1:0]    io_fail_node,
   output logic [CYC_W-1:0]     io_fail_cycle,
   output logic [NODES-1:0]     io_fail_en
);

   mon_state_e         state_q;
   mon_state_e         state_d;
   logic [CYC_W-1:0]   cyc_q;
   logic               err_mutex_q;
   logic               err_lock_q;
   logic               err_trans_q;
   logic               err_starve_q;
   logic [NODE_W-1:0]  fail_node_q;
   logic [NODE_W-1:0]  fail_node_d;
   logic [CYC_W-1:0]   fail_cycle_q;
   logic [NODES-1:0]   fail_en_q;

   logic [NODES-1:0]   trans_err;
   logic [NODES-1:0]   starve_err;
   logic [NODES-1:0]   in_crit;
   logic [NODES-1:0]   holds_lock;
   logic               check_trans;
   logic               mutex_err;
   logic               lock_err;
   logic               any_err;
   int unsigned        crit_cnt;
   logic [NODE_W-1:0]  crit_idx;
   logic [NODE_W-1:0]  trans_idx;
   logic [NODE_W-1:0]  starve_idx;

   // The ARM sample only establishes the reference, so steps are not judged against reset.
   assign check_trans = (state_q != MonArm);

   for (genvar k = 0; k < NODES; k++) begin : g_node
      mutex_node_checker #(
         .STARVE_LIMIT(STARVE_LIMIT)
      ) u_node (
         .clock      (clock),
         .reset      (reset),
         .check_trans(check_trans),
         .node_state (io_n_state[2*k +: 2]),
         .trans_err  (trans_err[k]),
         .starve_err (starve_err[k]),
         .in_crit    (in_crit[k]),
         .holds_lock (holds_lock[k])
      );
   end

   always_comb begin
      crit_cnt   = 0;
      crit_idx   = '0;
      trans_idx  = '0;
      starve_idx = '0;
      // Scanning downwards leaves the lowest offending index in each *_idx.
      for (int k = NODES - 1; k >= 0; k--) begin
         if (in_crit[k]) begin
            crit_cnt = crit_cnt + 1;
            crit_idx = NODE_W'(k);
         end
         if (trans_err[k]) trans_idx = NODE_W'(k);
         if (starve_err[k]) starve_idx = NODE_W'(k);
      end

      mutex_err = (crit_cnt > 1);
      lock_err  = io_x ? (|holds_lock) : !(|holds_lock);
      any_err   = mutex_err | lock_err | (|trans_err) | (|starve_err);

      if (mutex_err) begin
         fail_node_d = crit_idx;
      end else if (|trans_err) begin
         fail_node_d = trans_idx;
      end else if (|starve_err) begin
         fail_node_d = starve_idx;
      end else begin
         fail_node_d = crit_idx;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MonArm:  state_d = MonRun;
         MonRun:  if (any_err || io_fail) state_d = MonFail;
         MonFail: state_d = MonFail;
         default: state_d = MonArm;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= MonArm;
         cyc_q        <= '0;
         err_mutex_q  <= 1'b0;
         err_lock_q   <= 1'b0;
         err_trans_q  <= 1'b0;
         err_starve_q <= 1'b0;
         fail_node_q  <= '0;
         fail_cycle_q <= '0;
         fail_en_q    <= '0;
      end else begin
         state_q <= state_d;
         if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
         err_mutex_q  <= err_mutex_q | mutex_err;
         err_lock_q   <= err_lock_q | lock_err;
         err_trans_q  <= err_trans_q | (|trans_err);
         err_starve_q <= err_starve_q | (|starve_err);
         if (any_err && !io_fail) begin
            fail_node_q  <= fail_node_d;
            fail_cycle_q <= cyc_q;
            fail_en_q    <= io_en_a;
         end
      end
   end

   assign io_armed      = (state_q != MonArm);
   assign io_err_mutex  = err_mutex_q;
   assign io_err_lock   = err_lock_q;
   assign io_err_trans  = err_trans_q;
   assign io_err_starve = err_starve_q;
   assign io_fail       = err_mutex_q | err_lock_q | err_trans_q | err_starve_q;
   assign io_fail_node  = fail_node_q;
   assign io_fail_cycle = fail_cycle_q;
   assign io_fail_en    = fail_en_q;

endmodule

// File: doc/mutex_invariant_monitor.md
Name: mutex_invariant_monitor

Overview:
- Sits directly downstream of the generated `system` mutual-exclusion design; samples its per-node state registers and lock bit every cycle.
- Checks the protocol invariants and legal per-node transitions, and runs a per-node starvation watchdog.
- Latches sticky error flags plus first-failure diagnostics, so formal equivalence runs and simulation traces share one pass/fail source.

Parameters:
- NODES, 3, number of protocol nodes; matches the width of io_en_a in `system`.
- STARVE_LIMIT, 16, consecutive cycles a node may stay in TRY before a starvation flag is raised; legal range 1..2^CYC_W-1.
- CYC_W, 16, width of the cycle counter and of the captured failure cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_n_state  in  2*NODES  packed node states; node k in bits [2k+1:2k]; encoding 0=IDLE 1=TRY 2=CRIT 3=EXIT
- io_x  in  1  lock bit from `system`; 1=free, 0=held
- io_en_a  in  NODES  rule enable presented to `system` in the same cycle; used for diagnostics only
- io_armed  out  1  high once a reference sample has been taken
- io_err_mutex  out  1  sticky: more than one node in CRIT
- io_err_lock  out  1  sticky: lock inconsistent with CRIT/EXIT occupancy
- io_err_trans  out  1  sticky: illegal per-node transition
- io_err_starve  out  1  sticky: a node exceeded STARVE_LIMIT in TRY
- io_fail  out  1  OR of all err flags
- io_fail_node  out  $clog2(NODES)  node index of first failure
- io_fail_cycle  out  CYC_W  cycle count at first failure
- io_fail_en  out  NODES  io_en_a value at first failure

Behaviour:
- Reset, while asserted: all outputs 0, FSM=ARM, cycle counter 0, starvation counters 0, previous-state registers 0 (IDLE). Reset mid-operation clears everything, including sticky flags.
- FSM states:
  - ARM: first cycle after reset deasserts; captures io_n_state as the previous-state reference; sets io_armed=1; no transition check this cycle.
  - RUN: all checks active every cycle.
  - FAIL: entered on the first detected error. Diagnostics (node, cycle, en) are frozen. Flags stay sticky, and later errors of other types still OR into their flags. Only reset leaves FAIL.
- Transitions:
  - ARM -> RUN unconditionally.
  - RUN -> FAIL on any error.
  - RUN checks also run in the ARM cycle for mutex/lock invariants; only the transition check is skipped there.
- Cycle counter: increments every non-reset cycle, saturates at all-ones (no wrap).
- Mutex check: count of nodes in CRIT > 1 -> err_mutex.
- Lock check, failure cases (either sets err_lock):
  - io_x=1 while any node is in CRIT or EXIT.
  - io_x=0 while no node is in CRIT or EXIT.
- Transition check: per node, next==prev or next==(prev+1) mod 4; anything else -> err_trans.
  - Legal: IDLE->TRY, TRY->CRIT, CRIT->EXIT, EXIT->IDLE.
  - A node changing state while its io_en_a bit from the previous cycle was 0 is NOT an error; enables are diagnostic only.
- Starvation: per-node counter increments while the node is in TRY and clears on leaving TRY. Counter saturates at STARVE_LIMIT. On reaching STARVE_LIMIT -> err_starve.
- Output latency: all checks use current-cycle inputs; flags assert on the clock edge following the offending sample (1-cycle latency).
- Simultaneous errors in one cycle:
  - All applicable flags set together.
  - io_fail_node = lowest-indexed offending node, with priority mutex > trans > starve > lock.
  - For lock and mutex errors, io_fail_node = lowest node in CRIT, or 0 if none.

Decomposition:
- Package mutex_pkg holds:
  - node-state enum (IDLE/TRY/CRIT/EXIT, 2-bit)
  - the legal-successor function
  - the monitor FSM enum (ARM/RUN/FAIL)
- One sub-module is natural: mutex_node_checker, instantiated NODES times. It holds the previous state and starvation counter for one node, and outputs per-node trans_err, starve_err and in_crit / holds_lock bits. The top level does counting, priority encoding and capture.

Test Plan:
- Reset 1 cycle, all nodes IDLE, x=1, run 10 cycles -> io_armed=1 at cycle 1, io_fail=0 throughout.
- Node0 IDLE->TRY->CRIT (x 1->0)->EXIT->IDLE (x->1) over 4 cycles -> no flags.
- Drive node0=CRIT and node2=CRIT with x=0 at cycle 5 -> next edge: err_mutex=1, io_fail_node=0, io_fail_cycle=5.
- Node1 jumps IDLE->CRIT with x=0 at cycle 3 -> err_trans=1, io_fail_node=1, io_fail_en equals io_en_a sampled at cycle 3.
- Node2 held in TRY for 16 cycles, STARVE_LIMIT=16 -> err_starve rises exactly on the 16th TRY cycle. Assert reset mid-FAIL -> all flags 0 next cycle, io_armed=0.
- All nodes IDLE with x=0 -> err_lock=1, io_fail_node=0. Confirm the cycle counter saturates at 0xFFFF after 65535+ cycles without wrapping.
